pc_sequencer: RTL and testbench

- Instruction-fetch sequencer for the 5-stage MIPS pipeline. Owns the PC register and selects each cycle between PC+4, branch target (PC+4 + offset×4), J/JAL target and JR/JALR target.
- Generates the pipeline flush pulses for redirects.
- Drains and stops the pipeline on HALT, and provides a cycle counter for the debug unit.
- Sits between the hazard unit, the ID/EX branch/jump logic and the instruction memory address port.

---
 rtl/pc_sequencer.sv | 133 +++++++++++++
 tb/tb_pc_sequencer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Instruction-fetch sequencer: owns the PC, picks the next fetch address,
// raises redirect flushes and drains the pipeline into a halted state.
module pc_sequencer #(
    parameter int          B            = 32,
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          DRAIN_CYCLES = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         ena,
    input  logic         stall,
    input  logic         branch_taken,
    input  logic [B-1:0] branch_pc_plus4,
    input  logic [B-1:0] branch_offset,
    input  logic         jump,
    input  logic [25:0]  jump_index,
    input  logic         jump_reg,
    input  logic [B-1:0] jump_reg_addr,
    input  logic         halt_detected,
    output logic [B-1:0] pc_out,
    output logic [B-1:0] pc_plus4,
    output logic         fetch_valid,
    output logic         flush_if_id,
    output logic         flush_id_ex,
    output logic         halted,
    output logic [B-1:0] cycle_count
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    localparam logic [3:0]   DRAIN_INIT = 4'(DRAIN_CYCLES - 1);
    localparam logic [B-1:0] PC_INIT    = B'(RESET_PC);

    state_t       state_q, state_d;
    logic [B-1:0] pc_q, pc_d;
    logic [3:0]   drain_cnt_q, drain_cnt_d;
    logic [B-1:0] cycle_q, cycle_d;

    logic [B-1:0] branch_target;
    logic [B-1:0] jump_target;
    logic         flush_if_id_raw;
    logic         flush_id_ex_raw;

    assign pc_plus4      = pc_q + B'(4);
    assign branch_target = branch_pc_plus4 + (branch_offset << 2);
    assign jump_target   = {pc_plus4[B-1:28], jump_index, 2'b00};

    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        drain_cnt_d     = drain_cnt_q;
        fetch_valid     = 1'b0;
        flush_if_id_raw = 1'b0;
        flush_id_ex_raw = 1'b0;

        case (state_q)
            RUN: begin
                fetch_valid = 1'b1;
                if (branch_taken) begin
                    pc_d            = branch_target;
                    fetch_valid     = 1'b0;
                    flush_if_id_raw = 1'b1;
                    flush_id_ex_raw = 1'b1;
                // A stalled jump must not redirect; it is retried once the stall clears
                end else if (stall && (jump || jump_reg)) begin
                    pc_d = pc_q;
                end else if (jump_reg) begin
                    pc_d            = jump_reg_addr;
                    fetch_valid     = 1'b0;
                    flush_if_id_raw = 1'b1;
                end else if (jump) begin
                    pc_d            = jump_target;
                    fetch_valid     = 1'b0;
                    flush_if_id_raw = 1'b1;
                end else if (halt_detected) begin
                    state_d     = DRAIN;
                    drain_cnt_d = DRAIN_INIT;
                end else if (!stall) begin
                    pc_d = pc_plus4;
                end
            end
            DRAIN: begin
                flush_if_id_raw = 1'b1;
                // A taken branch here means the HALT sat on a wrong path
                if (branch_taken) begin
                    pc_d            = branch_target;
                    flush_id_ex_raw = 1'b1;
                    state_d         = RUN;
                end else if (drain_cnt_q == 4'd0) begin
                    state_d = HALTED;
                end else begin
                    drain_cnt_d = drain_cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase
    end

    always_comb begin
        cycle_d = cycle_q;
        if ((state_q != HALTED) && (cycle_q != '1)) begin
            cycle_d = cycle_q + B'(1);
        end
    end

    assign flush_if_id = flush_if_id_raw && ena && !reset;
    assign flush_id_ex = flush_id_ex_raw && ena && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RUN;
            pc_q        <= PC_INIT;
            drain_cnt_q <= 4'd0;
            cycle_q     <= '0;
        end else if (ena) begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            drain_cnt_q <= drain_cnt_d;
            cycle_q     <= cycle_d;
        end
    end

    assign pc_out      = pc_q;
    assign halted      = (state_q == HALTED);
    assign cycle_count = cycle_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: a behavioural model predicts each edge's
// registered outputs, which are queued at drive time and compared after the edge.
module tb_pc_sequencer;

    logic        clk;
    logic        reset;
    logic        ena;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_pc_plus4;
    logic [31:0] branch_offset;
    logic        jump;
    logic [25:0] jump_index;
    logic        jump_reg;
    logic [31:0] jump_reg_addr;
    logic        halt_detected;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic        fetch_valid;
    logic        flush_if_id;
    logic        flush_id_ex;
    logic        halted;
    logic [31:0] cycle_count;

    pc_sequencer #(.B(32), .RESET_PC(32'h0), .DRAIN_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .ena(ena), .stall(stall),
        .branch_taken(branch_taken), .branch_pc_plus4(branch_pc_plus4),
        .branch_offset(branch_offset), .jump(jump), .jump_index(jump_index),
        .jump_reg(jump_reg), .jump_reg_addr(jump_reg_addr),
        .halt_detected(halt_detected), .pc_out(pc_out), .pc_plus4(pc_plus4),
        .fetch_valid(fetch_valid), .flush_if_id(flush_if_id),
        .flush_id_ex(flush_id_ex), .halted(halted), .cycle_count(cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        hlt;
        logic [31:0] cyc;
    } expect_t;

    expect_t scoreboard[$];

    int num_checks = 0;
    int num_fails  = 0;

    // Model state: 0 = running, 1 = draining, 2 = halted
    logic [31:0] m_pc;
    int          m_state;
    int          m_cnt;
    logic [31:0] m_cyc;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        num_checks++;
        if (observed !== expected) begin
            num_fails++;
            $display("[TB] FAIL %s: observed %h expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic rs, input logic en, input logic bt,
                                 input logic [31:0] bpc, input logic [31:0] boff,
                                 input logic st, input logic j, input logic [25:0] ji,
                                 input logic jr, input logic [31:0] jra, input logic hd);
        logic        redirect;
        logic        e_fv, e_fif, e_fie;
        logic [31:0] target;
        expect_t     e, got;
        @(negedge clk);
        reset = rs; ena = en; branch_taken = bt; branch_pc_plus4 = bpc;
        branch_offset = boff; stall = st; jump = j; jump_index = ji;
        jump_reg = jr; jump_reg_addr = jra; halt_detected = hd;
        #1;
        target = bpc + {boff[29:0], 2'b00};
        e_fv = 1'b0; e_fif = 1'b0; e_fie = 1'b0;
        if (m_state == 0) begin
            redirect = bt || (!st && (jr || j));
            e_fv  = !redirect;
            e_fif = redirect;
            e_fie = bt;
        end else if (m_state == 1) begin
            e_fif = 1'b1;
            e_fie = bt;
        end
        if (rs || !en) begin
            e_fif = 1'b0;
            e_fie = 1'b0;
        end
        if (!rs) checkOutput("fetch_valid", {31'b0, fetch_valid}, {31'b0, e_fv});
        checkOutput("flush_if_id", {31'b0, flush_if_id}, {31'b0, e_fif});
        checkOutput("flush_id_ex", {31'b0, flush_id_ex}, {31'b0, e_fie});

        if (rs) begin
            m_pc = 32'h0; m_state = 0; m_cnt = 0; m_cyc = 32'h0;
        end else if (en) begin
            if (m_state != 2 && m_cyc != 32'hFFFF_FFFF) m_cyc = m_cyc + 1;
            if (m_state == 0) begin
                if (bt) m_pc = target;
                else if (st && (j || jr)) m_pc = m_pc;
                else if (jr) m_pc = jra;
                else if (j) m_pc = {m_pc[31:28] + ((m_pc[27:0] >= 28'hFFFFFFC) ? 4'd1 : 4'd0), ji, 2'b00};
                else if (hd) begin m_state = 1; m_cnt = 3; end
                else if (!st) m_pc = m_pc + 32'd4;
            end else if (m_state == 1) begin
                if (bt) begin m_pc = target; m_state = 0; end
                else if (m_cnt == 0) m_state = 2;
                else m_cnt = m_cnt - 1;
            end
        end
        e.pc = m_pc; e.hlt = (m_state == 2); e.cyc = m_cyc;
        scoreboard.push_back(e);

        @(posedge clk);
        #1;
        got = scoreboard.pop_front();
        checkOutput("pc_out", pc_out, got.pc);
        checkOutput("pc_plus4", pc_plus4, got.pc + 32'd4);
        checkOutput("halted", {31'b0, halted}, {31'b0, got.hlt});
        checkOutput("cycle_count", cycle_count, got.cyc);
    endtask

    task automatic stepIdle(input int n);
        for (int i = 0; i < n; i++)
            applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic stepBranch(input logic [31:0] bpc, input logic [31:0] boff);
        applyStimulus(0, 1, 1, bpc, boff, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic stepReset();
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        reset = 1'b1; ena = 1'b0; stall = 1'b0; branch_taken = 1'b0;
        branch_pc_plus4 = '0; branch_offset = '0; jump = 1'b0; jump_index = '0;
        jump_reg = 1'b0; jump_reg_addr = '0; halt_detected = 1'b0;
        m_pc = 32'h0; m_state = 0; m_cnt = 0; m_cyc = 32'h0;

        stepReset();
        stepReset();
        checkOutput("reset_pc", pc_out, 32'h0);

        // Sequential fetch
        stepIdle(5);
        checkOutput("seq_cycles", cycle_count, 32'd5);
        checkOutput("seq_pc", pc_out, 32'h14);

        // Taken branch with negative offset
        stepBranch(32'h20, 32'hFFFF_FFFC);
        checkOutput("branch_target", pc_out, 32'h10);

        // Branch beats stall and jump, then a lone stall holds
        applyStimulus(0, 1, 1, 32'h30, 32'h4, 1, 1, 26'h3, 0, 0, 0);
        checkOutput("branch_prio", pc_out, 32'h40);
        applyStimulus(0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        checkOutput("stall_hold", pc_out, 32'h40);

        // J and JR targets
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 1, 32'h1000_0004, 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 1, 26'h0000010, 0, 0, 0);
        checkOutput("j_target", pc_out, 32'h1000_0040);
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 1, 32'h0000_ABC0, 0);
        checkOutput("jr_target", pc_out, 32'hABC0);

        // Stalled jump holds, then retries
        applyStimulus(0, 1, 0, 0, 0, 1, 1, 26'h100, 0, 0, 0);
        checkOutput("jump_stalled", pc_out, 32'hABC0);
        applyStimulus(0, 1, 0, 0, 0, 0, 1, 26'h100, 0, 0, 0);
        checkOutput("jump_retry", pc_out, 32'h400);

        // ena=0 freezes state and suppresses flushes
        applyStimulus(0, 0, 1, 32'h80, 32'h0, 0, 0, 0, 0, 0, 0);
        checkOutput("ena_freeze", pc_out, 32'h400);

        // Halt drain at pc 0x30
        stepBranch(32'h30, 32'h0);
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        checkOutput("halt_pc", pc_out, 32'h30);
        for (int i = 0; i < 4; i++)
            applyStimulus(0, 1, 0, 0, 0, 1, 1, 26'h5, 1, 32'h44, 1);
        checkOutput("halted_set", {31'b0, halted}, 32'd1);
        for (int i = 0; i < 4; i++)
            applyStimulus(0, i[0], 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("halt_pc_frozen", pc_out, 32'h30);

        // Reset from HALTED
        stepReset();
        checkOutput("rst_halted", {31'b0, halted}, 32'd0);
        checkOutput("rst_cycles", cycle_count, 32'd0);

        // Abort drain with a branch in the second DRAIN cycle
        stepIdle(3);
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        stepIdle(1);
        stepBranch(32'h100, 32'h8);
        checkOutput("abort_pc", pc_out, 32'h120);
        stepIdle(2);
        checkOutput("abort_run", pc_out, 32'h128);

        // Random mixed traffic
        for (int i = 0; i < 60; i++) begin
            applyStimulus(0, ($urandom_range(0, 7) != 0),
                          ($urandom_range(0, 7) == 0), $urandom, $urandom,
                          ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
                          26'($urandom), ($urandom_range(0, 7) == 0), $urandom,
                          ($urandom_range(0, 15) == 0));
        end
        stepReset();
        checkOutput("final_reset_pc", pc_out, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
        $finish;
    end

endmodule
